// File: rtl/mono_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// mono_mode_ctrl_if
// Purpose : bundles the keyboard byte stream, the VGA vsync input and the
//           monochrome-mode outputs of mono_mode_ctrl into one interface.
// Signals : scan_code[7:0]           PS/2 set-2 byte, valid while scan_valid=1
//           scan_valid               one-cycle strobe per received byte
//           vsync                    VGA vertical sync (clk_vga domain)
//           monochrome_switcher[1:0] 00 colour, 01 green, 10 amber, 11 grey
//           mode_pending             requested mode not yet applied
//           mode_changed             one-cycle pulse when the mode updates
// Modports: master drives keyboard/vsync side, slave is the controller.
// ---------------------------------------------------------------------------
interface mono_mode_ctrl_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       vsync;
    logic [1:0] monochrome_switcher;
    logic       mode_pending;
    logic       mode_changed;

    modport master (
        output scan_code, scan_valid, vsync,
        input  monochrome_switcher, mode_pending, mode_changed
    );

    modport slave (
        input  scan_code, scan_valid, vsync,
        output monochrome_switcher, mode_pending, mode_changed
    );
endinterface

// File: rtl/mono_mode_ctrl.sv
// ---------------------------------------------------------------------------
// mono_mode_ctrl
// Purpose : decodes a PS/2 set-2 byte stream and cycles a monochrome display
//           mode on each Scroll Lock press (Ctrl+Scroll Lock returns to
//           colour). The requested mode is kept as a target and applied to
//           monochrome_switcher either at the vsync leading edge or, in the
//           default build, on the clock after the target changes.
// Ports   : clk_vga  single clock for all logic
//           rst_n    asynchronous active-low reset
//           bus      mono_mode_ctrl_if.slave (scan_code, scan_valid, vsync,
//                    monochrome_switcher, mode_pending, mode_changed)
// Params  : VSYNC_ACTIVE_LOW 1 = vsync pulse low, 0 = vsync pulse high
//           PREFIX_TIMEOUT   idle clocks allowed inside a multi-byte sequence
// Config  : define MONO_VSYNC_APPLY_EN to apply mode changes at the vsync
//           leading edge; undefined, vsync is ignored and the target is
//           applied one clock after it changes.
// ---------------------------------------------------------------------------
module mono_mode_ctrl #(
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int PREFIX_TIMEOUT   = 65535
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    mono_mode_ctrl_if.slave    bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_E0      = 3'd1;
    localparam logic [2:0] ST_F0      = 3'd2;
    localparam logic [2:0] ST_E0F0    = 3'd3;
    localparam logic [2:0] ST_SKIP_E1 = 3'd4;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_E1     = 8'hE1;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_SCROLL = 8'h7E;

    // Pause is E1 followed by seven more bytes that carry no key meaning.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int IDLE_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        (PREFIX_TIMEOUT > 0) ? IDLE_W'(PREFIX_TIMEOUT - 1) : '0;

    logic [2:0]        state_q, state_d;
    logic [2:0]        skip_q, skip_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic       key_make;
    logic       key_break;
    logic       key_ext;

    logic       lctrl_q;
    logic       rctrl_q;
    logic       ctrl_held;
    logic       scroll_held_q;
    logic [1:0] target_q;
    logic [1:0] switcher_q;
    logic       changed_q;
    logic       pending;
    logic       apply;
    logic       scroll_press;

    // ------------------------------------------------------------------
    // Byte decoder: classifies each byte as make/break (plain/extended)
    // and tracks prefix state plus the idle timeout inside a sequence.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        skip_d    = skip_q;
        idle_d    = idle_q;
        key_make  = 1'b0;
        key_break = 1'b0;
        key_ext   = 1'b0;

        if (bus.scan_valid) begin
            idle_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == CODE_E0) begin
                        state_d = ST_E0;
                    end else if (bus.scan_code == CODE_F0) begin
                        state_d = ST_F0;
                    end else if (bus.scan_code == CODE_E1) begin
                        state_d = ST_SKIP_E1;
                        skip_d  = PAUSE_TAIL;
                    end else begin
                        key_make = 1'b1;
                    end
                end
                ST_E0: begin
                    if (bus.scan_code == CODE_F0) begin
                        state_d = ST_E0F0;
                    end else begin
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_F0: begin
                    key_break = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_E0F0: begin
                    key_break = 1'b1;
                    key_ext   = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_SKIP_E1: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = '0;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled sequence is abandoned silently once the keyboard has
            // been quiet for PREFIX_TIMEOUT clocks.
            if (idle_q == IDLE_LAST) begin
                state_d = ST_IDLE;
                skip_d  = '0;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            idle_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values of the others.
            state_q <= state_d;
            skip_q  <= skip_d;
            idle_q  <= idle_d;
        end
    end

    // ------------------------------------------------------------------
    // Key state and mode target
    // ------------------------------------------------------------------
    // Left Ctrl is plain 14, right Ctrl is E0 14; Ctrl counts as held until
    // both have been released.
    assign ctrl_held = lctrl_q | rctrl_q;

    // Only the first make of Scroll Lock counts; typematic repeats arrive
    // while the key is still held and are ignored.
    assign scroll_press = key_make && !key_ext &&
                          (bus.scan_code == CODE_SCROLL) && !scroll_held_q;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            lctrl_q       <= 1'b0;
            rctrl_q       <= 1'b0;
            scroll_held_q <= 1'b0;
            target_q      <= 2'b00;
        end else begin
            if (bus.scan_code == CODE_CTRL) begin
                if (key_make && !key_ext)  lctrl_q <= 1'b1;
                if (key_break && !key_ext) lctrl_q <= 1'b0;
                if (key_make && key_ext)   rctrl_q <= 1'b1;
                if (key_break && key_ext)  rctrl_q <= 1'b0;
            end
            if (bus.scan_code == CODE_SCROLL && !key_ext) begin
                if (key_make)  scroll_held_q <= 1'b1;
                if (key_break) scroll_held_q <= 1'b0;
            end
            // Built from the latest target, so presses within one frame
            // accumulate before being applied.
            if (scroll_press) begin
                target_q <= ctrl_held ? 2'b00 : target_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode application
    // ------------------------------------------------------------------
    assign pending = (target_q != switcher_q);

`ifdef MONO_VSYNC_APPLY_EN
    localparam logic VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic vsync_q;
    logic vsync_active;
    logic vsync_active_q;

    assign vsync_active   = (VSYNC_ACTIVE_LOW != 0) ? ~bus.vsync : bus.vsync;
    assign vsync_active_q = (VSYNC_ACTIVE_LOW != 0) ? ~vsync_q   : vsync_q;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= VSYNC_IDLE;
        end else begin
            vsync_q <= bus.vsync;
        end
    end

    // A target written in the same cycle as the edge is still old here, so
    // it waits for the following frame.
    assign apply = vsync_active && !vsync_active_q && pending;
`else
    logic unused_vsync;
    assign unused_vsync = bus.vsync;
    assign apply        = pending;
`endif

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            switcher_q <= 2'b00;
            changed_q  <= 1'b0;
        end else begin
            changed_q <= apply;
            if (apply) begin
                switcher_q <= target_q;
            end
        end
    end

    assign bus.monochrome_switcher = switcher_q;
    assign bus.mode_pending        = pending;
    assign bus.mode_changed        = changed_q;

endmodule

// File: doc/mono_mode_ctrl.md
MONO_MODE_CTRL -- requirements
Module: mono_mode_ctrl

Interface
REQ-001 SHALL have parameter VSYNC_ACTIVE_LOW, default 1: 1 = vsync pulse is low, 0 = vsync pulse is high.
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 65535: maximum idle clocks allowed inside a multi-byte scan-code sequence.
REQ-003 SHALL have port clk_vga, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port scan_code, input, 8: PS/2 set-2 byte, valid only while scan_valid=1.
REQ-006 SHALL have port scan_valid, input, 1: one-cycle strobe per received byte.
REQ-007 SHALL have port vsync, input, 1: VGA vertical sync, synchronous to clk_vga.
REQ-008 SHALL have port monochrome_switcher, output, 2: 00 colour, 01 green, 10 amber, 11 grey.
REQ-009 SHALL have port mode_pending, output, 1: a requested mode is waiting to be applied.
REQ-010 SHALL have port mode_changed, output, 1: one-cycle pulse in the cycle monochrome_switcher updates.

Function
REQ-011 SHALL decode bytes with FSM states IDLE, E0, F0, E0F0, SKIP_E1.
- IDLE: E0->E0, F0->F0, E1->SKIP_E1 with skip count 7; any other byte is a make code.
- E0: F0->E0F0; other byte = extended make, then IDLE.
- F0 / E0F0: byte = break (plain / extended), then IDLE.
REQ-012 SHALL stay in SKIP_E1 until 7 further bytes are consumed, with no key effect (Pause sequence), then return to IDLE.
REQ-013 SHALL track ctrl_held: set on make 14 or E0 14; cleared only when both left and right Ctrl have seen break.
REQ-014 SHALL track scroll_held: set on make 7E, cleared on break 7E.
REQ-015 On make 7E with scroll_held=0 and ctrl_held=0, SHALL set target = (current target + 1) mod 4.
REQ-016 On make 7E with scroll_held=0 and ctrl_held=1, SHALL set target = 00.
REQ-017 SHALL ignore typematic repeats of 7E (make while scroll_held=1).
REQ-018 SHALL assert mode_pending while target != monochrome_switcher.
REQ-019 SHALL compute target from the latest target, not the applied mode, so several presses within one frame accumulate.
REQ-020 SHALL detect the vsync leading edge from a 1-cycle registered copy of vsync, honouring VSYNC_ACTIVE_LOW.
REQ-021 On that edge with mode_pending=1, SHALL load monochrome_switcher <= target and pulse mode_changed for exactly one cycle.
REQ-022 When the vsync edge and a target update fall in the same cycle, SHALL apply the pre-update target; the new target applies at the next edge.
REQ-023 SHALL count idle clocks in any non-IDLE state; when the count reaches PREFIX_TIMEOUT, SHALL return to IDLE with no key effect.
REQ-024 SHALL restart the idle count on every scan_valid.
REQ-025 SHALL ignore scan_code while scan_valid=0.

Reset
REQ-026 While rst_n=0, SHALL hold: FSM=IDLE, skip count 0, timeout count 0, ctrl/scroll held flags 0, target 00, monochrome_switcher 00, mode_pending 0, mode_changed 0, vsync register at its inactive level.
REQ-027 Reset asserted mid-sequence SHALL discard the partial sequence; the first byte after release is decoded from IDLE.

Configuration
REQ-028 SHALL use macro MONO_VSYNC_APPLY_EN.
- Defined: mode is applied at the vsync edge as in REQ-020..022.
- Undefined: monochrome_switcher <= target on the clock after target changes, with a mode_changed pulse; vsync is unused and mode_pending is at most 1 cycle high.

Verification
REQ-029 Press 7E, release F0 7E, then vsync edge -> mode_pending=1 until the edge; switcher 01 with one mode_changed pulse.
REQ-030 7E,7E,7E (repeats) then F0 7E in one frame -> switcher 01 after the edge, not 11.
REQ-031 From 10: E0 14, 7E, F0 7E, E0 F0 14 -> switcher 00 at the next edge; ctrl_held=0 at the end.
REQ-032 E1 14 77 E1 F0 14 F0 77, then 7E -> ctrl_held stays 0; mode advances by exactly one.
REQ-033 E0 followed by PREFIX_TIMEOUT idle clocks, then 7E -> treated as plain make; mode advances.
REQ-034 rst_n low between F0 and 7E -> all outputs 0; next byte 7E is decoded as a make.
